// File: rtl/blank_window_arbiter_if.sv
// blank_window_arbiter_if: timing coordinates, request levels and grant outputs of the blanking-window arbiter
interface blank_window_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic signed [12:0]   i_x;
    logic signed [12:0]   i_y;
    logic [NUM_REQ-1:0]   i_req;
    logic [NUM_REQ-1:0]   o_gnt;
    logic                 o_preempt;
    logic                 o_window;

    modport master (
        output i_x, i_y, i_req,
        input  o_gnt, o_preempt, o_window
    );

    modport slave (
        input  i_x, i_y, i_req,
        output o_gnt, o_preempt, o_window
    );
endinterface

// File: rtl/blank_window_arbiter.sv
// blank_window_arbiter: round-robin port arbiter granting only during blanking; BLANK_ARB_HBLANK_EN adds horizontal-blanking grants
module blank_window_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int GUARD     = 4
) (
    input  logic                   i_pixel_clk,
    input  logic                   i_reset,
    blank_window_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic signed [12:0] NEG_GUARD = 13'(-GUARD);

    typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

    state_t             state_q;
    logic [IW-1:0]      rr_q;
    logic [IW-1:0]      win_q;
    logic [IW-1:0]      win_d;
    logic [CW-1:0]      cnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               preempt_q;
    logic               window_q;
    logic               window_open;

`ifdef BLANK_ARB_HBLANK_EN
    assign window_open = bus.i_y[12] || (bus.i_x < NEG_GUARD);
`else
    logic unused_x;
    assign window_open = bus.i_y[12];
    assign unused_x = ^{bus.i_x, NEG_GUARD};
`endif

    // Winner: first asserted request at or after the rr pointer, searching upward with wrap
    always_comb begin
        win_d = rr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.i_req[j]) win_d = IW'(j);
        end
    end

    // Grant FSM: IDLE picks a winner, GRANT runs the burst, HOLDOFF forces a one-cycle gap
    always_ff @(posedge i_pixel_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            preempt_q <= 1'b0;
            window_q  <= 1'b0;
        end else begin
            window_q <= window_open;
            case (state_q)
                IDLE: begin
                    preempt_q <= 1'b0;
                    if (window_open && |bus.i_req) begin
                        state_q <= GRANT;
                        win_q   <= win_d;
                        gnt_q   <= NUM_REQ'(1) << win_d;
                        cnt_q   <= CW'(1);
                        rr_q    <= (win_d == IW'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;
                    end
                end
                GRANT: begin
                    if (!bus.i_req[win_q] || cnt_q == CW'(MAX_BURST) || !window_open) begin
                        state_q   <= HOLDOFF;
                        gnt_q     <= '0;
                        preempt_q <= bus.i_req[win_q];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLDOFF: begin
                    state_q   <= IDLE;
                    preempt_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.o_gnt     = gnt_q;
    assign bus.o_preempt = preempt_q;
    assign bus.o_window  = window_q;
endmodule

// File: tb/tb_blank_window_arbiter.sv
// tb_blank_window_arbiter: directed checks of the blanking-window arbiter with a 640x480 coordinate sweep
module tb_blank_window_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    blank_window_arbiter_if #(.NUM_REQ(4)) bus ();

    blank_window_arbiter #(
        .NUM_REQ(4),
        .MAX_BURST(8),
        .GUARD(4)
    ) dut (
        .i_pixel_clk(clk),
        .i_reset(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One pixel clock, then advance the coordinate generator to the next pixel
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.i_x == 13'sd639) begin
            bus.i_x = -13'sd160;
            bus.i_y = (bus.i_y == 13'sd479) ? -13'sd45 : bus.i_y + 13'sd1;
        end else begin
            bus.i_x = bus.i_x + 13'sd1;
        end
    endtask

    initial begin
        int xv;
        logic [3:0] eg;
        logic ep, ew;
        bus.i_x   = -13'sd100;
        bus.i_y   = -13'sd20;
        bus.i_req = 4'b0000;
        rst = 1'b1;
        tick();
        tick();
        check("reset_gnt", bus.o_gnt, 4'b0000);
        check("reset_preempt", bus.o_preempt, 1'b0);
        check("reset_window", bus.o_window, 1'b0);

        rst = 1'b0;
        bus.i_req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("burst_gnt", bus.o_gnt, 4'b0100);
            check("burst_preempt", bus.o_preempt, 1'b0);
        end
        check("burst_window", bus.o_window, 1'b1);
        tick();
        check("limit_gnt", bus.o_gnt, 4'b0000);
        check("limit_preempt", bus.o_preempt, 1'b1);
        tick();
        check("gap_gnt", bus.o_gnt, 4'b0000);
        check("gap_preempt", bus.o_preempt, 1'b0);
        tick();
        check("regrant_gnt", bus.o_gnt, 4'b0100);

        rst = 1'b1;
        bus.i_req = 4'b1111;
        tick();
        check("rst2_gnt", bus.o_gnt, 4'b0000);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            for (int j = 0; j < 8; j++) begin
                tick();
                check("rr_gnt", bus.o_gnt, eg);
            end
            if (k < 4) begin
                tick();
                check("rr_gap1_gnt", bus.o_gnt, 4'b0000);
                check("rr_gap1_preempt", bus.o_preempt, 1'b1);
                tick();
                check("rr_gap2_gnt", bus.o_gnt, 4'b0000);
            end
        end

        rst = 1'b1;
        bus.i_req = 4'b0000;
        tick();
        rst = 1'b0;
        bus.i_req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rel_gnt", bus.o_gnt, 4'b0010);
        end
        bus.i_req = 4'b0000;
        tick();
        check("rel_drop_gnt", bus.o_gnt, 4'b0000);
        check("rel_drop_preempt", bus.o_preempt, 1'b0);
        bus.i_req = 4'b1111;
        tick();
        check("rel_idle_gnt", bus.o_gnt, 4'b0000);
        check("rel_idle_preempt", bus.o_preempt, 1'b0);
        tick();
        check("rel_next_gnt", bus.o_gnt, 4'b0100);

        rst = 1'b1;
        bus.i_req = 4'b0000;
        tick();
        rst = 1'b0;
        bus.i_x = -13'sd10;
        bus.i_y = 13'sd100;
        bus.i_req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            xv = bus.i_x;
`ifdef BLANK_ARB_HBLANK_EN
            eg = (xv >= -9 && xv <= -4) ? 4'b0001 : 4'b0000;
            ep = (xv == -3);
            ew = (xv <= -4);
`else
            eg = 4'b0000;
            ep = 1'b0;
            ew = 1'b0;
`endif
            check("hb_gnt", bus.o_gnt, eg);
            check("hb_preempt", bus.o_preempt, ep);
            check("hb_window", bus.o_window, ew);
        end

        rst = 1'b1;
        bus.i_req = 4'b0000;
        tick();
        rst = 1'b0;
        bus.i_x = -13'sd100;
        bus.i_y = -13'sd30;
        bus.i_req = 4'b0100;
        tick();
        check("mid_gnt1", bus.o_gnt, 4'b0100);
        tick();
        check("mid_gnt2", bus.o_gnt, 4'b0100);
        rst = 1'b1;
        tick();
        check("mid_rst_gnt", bus.o_gnt, 4'b0000);
        check("mid_rst_preempt", bus.o_preempt, 1'b0);
        rst = 1'b0;
        bus.i_req = 4'b1010;
        tick();
        check("mid_after_gnt", bus.o_gnt, 4'b0010);

        rst = 1'b1;
        bus.i_req = 4'b0000;
        tick();
        rst = 1'b0;
        bus.i_x = 13'sd630;
        bus.i_y = 13'sd479;
        bus.i_req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("wrap_pre_gnt", bus.o_gnt, 4'b0000);
        end
        tick();
        check("wrap_x", 32'(bus.i_x), 32'(-13'sd159));
        check("wrap_gnt", bus.o_gnt, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/blank_window_arbiter.md
# blank_window_arbiter

Round-robin arbiter that shares one memory/register port (framebuffer, palette, sprite RAM) among NUM_REQ requesters. It grants only while the pixel timing generator is in blanking, so scanout owns the port during visible picture. The block consumes the generator's signed x/y coordinates (negative in blanking, (0,0) top-left of visible area). It sits beside the timing generator in the pixel clock domain.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- MAX_BURST, 16: max consecutive grant cycles per grant, 1..255
- GUARD, 4: grants close GUARD pixels before each visible line starts, ≥1, < H blanking length
- i_pixel_clk  in  1  pixel clock; the only clock
- i_reset  in  1  synchronous, active-high reset
- i_x  in  13 signed  current screen x from the timing generator
- i_y  in  13 signed  current screen y from the timing generator
- i_req  in  NUM_REQ  per-requester request level, held high while the port is wanted
- o_gnt  out  NUM_REQ  registered one-hot grant; all-zero when idle
- o_preempt  out  1  one-cycle pulse when a grant is removed by force
- o_window  out  1  registered copy of the combinational window-open term

## Operation
- window_open (combinational): true when i_y < 0; otherwise gated by HBLANK grant enable (see Configuration).
- State machine, with state encoded so o_gnt ≠ 0 exactly in GRANT:
  - IDLE: if window_open and |i_req, enter GRANT; o_gnt = one-hot winner; burst counter = 1; rr pointer = (winner+1) mod NUM_REQ.
  - GRANT: burst counter increments each cycle. Leave to HOLDOFF when any of these holds: i_req[winner] low (release), counter == MAX_BURST, or !window_open.
  - HOLDOFF: o_gnt = 0; unconditionally go to IDLE on the next edge.
- Winner: first asserted i_req at or after the rr pointer, searching cyclically upward.
- o_preempt: high during the HOLDOFF cycle only when GRANT was left while i_req[winner] was still high (burst limit or window close). When burst limit and window close coincide, there is one pulse. When i_req drops in the same cycle as either, there is no pulse (release wins).
- A transfer is valid only in cycles where both o_gnt[k] and i_req[k] are high. The requester may see o_gnt for one cycle after dropping i_req and must ignore it.
- Burst counter width: clog2(MAX_BURST+1); it never wraps because GRANT exits at MAX_BURST.

## Timing
- Reset values: o_gnt = 0, o_preempt = 0, o_window = 0, state IDLE, rr pointer 0, burst counter 0.
- Request-to-grant latency: 1 cycle, i.e. i_req sampled high in IDLE with window open gives o_gnt on the next cycle.
- Grant duration: at most MAX_BURST consecutive cycles.
- Minimum gap between two grants is 2 cycles with o_gnt = 0 (HOLDOFF, then IDLE).
- Window close: o_gnt is low from the cycle after window_open falls. On a visible line, o_gnt is therefore zero for x ≥ -GUARD+1, which guarantees at least GUARD-1 idle cycles before x = 0.
- Frame wrap (y jumping from V_RESOLUTION-1 to the negative start value): no special handling. The window reopens by the y < 0 rule.
- i_reset asserted mid-grant: o_gnt = 0 on the next cycle, no o_preempt pulse, pointer returns to 0.
- i_req changes outside IDLE/GRANT evaluation are ignored; no request is latched.

## Configuration
- BLANK_ARB_HBLANK_EN defined: on visible lines (i_y ≥ 0), window_open = (i_x < -GUARD), so grants are also issued in the horizontal blanking of visible lines.
- BLANK_ARB_HBLANK_EN undefined: window_open = (i_y < 0) only, so grants are issued in vertical blanking only and GUARD is unused.

## Test plan
Parameters: NUM_REQ=4, MAX_BURST=8, GUARD=4, with 640x480 generator (x from -160..639, y from -45..479).
- Reset, then y=-20, i_req=4'b0100 held → o_gnt=4'b0100 one cycle later for 8 cycles, then o_preempt pulse, o_gnt=0 for 2 cycles, then 4'b0100 again.
- i_req=4'b1111 held through vblank → grant order 0001, 0010, 0100, 1000, 0001; each grant 8 cycles; 2 idle cycles between grants.
- Requester 1 granted, drops i_req after 3 grant cycles → o_gnt=0 the following cycle, no o_preempt, pointer now selects requester 2 first.
- HBLANK_EN defined, y=100, i_req=4'b0001 raised at x=-10 → grant from x=-9 through x=-4, o_gnt=0 at x=-3, o_preempt at x=-3. With the macro undefined, no grant at all on line 100.
- i_reset pulsed during an active grant at y=-30 → o_gnt=0 next cycle, o_preempt=0; next grant with i_req=4'b1010 goes to requester 1.
- Grant active when y wraps from 479 to -45 (macro undefined): no grant occurs before the wrap; a request held across the wrap is granted at x=-159, y=-45.
